// File: rtl/host_input_loader.sv
// Host input loader: accepts host words over a valid/ready handshake,
// buffers them in a small FIFO and writes exactly LOAD_DEPTH words to
// consecutive on-chip memory addresses whenever the arbiter grants access.
module host_input_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11,
  parameter int FIFO_DEPTH = 8,
  parameter int LOAD_DEPTH = 256,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] host_data_in,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic                  mem_grant,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  busy,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]      LOAD_DEPTH_C = CNT_W'(LOAD_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BASE_C       = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [PTR_W:0]        FIFO_FULL_C  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        fifo_cnt_q, fifo_cnt_d;
  logic [CNT_W-1:0]      accepted_q, accepted_d;
  logic [CNT_W-1:0]      written_q, written_d;
  logic                  host_ready_q, host_ready_d;
  logic                  mem_wr_en_q;
  logic [ADDR_WIDTH-1:0] mem_address_q;
  logic [DATA_WIDTH-1:0] mem_data_q;
  logic                  busy_q;
  logic                  load_done_q;
  logic                  push_s;
  logic                  pop_s;

  // Next-state logic: handshake, FIFO occupancy, counters and FSM transitions.
  always_comb begin
    push_s       = host_valid && host_ready_q && (state_q == S_LOAD);
    // Pop only uses the registered occupancy, so a word pushed this cycle
    // cannot be written before the next cycle.
    pop_s        = ((state_q == S_LOAD) || (state_q == S_DRAIN)) &&
                   (fifo_cnt_q != '0) && mem_grant;
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_cnt_d   = fifo_cnt_q;
    accepted_d   = accepted_q;
    written_d    = written_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          fifo_cnt_d = '0;
          accepted_d = '0;
          written_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(push_s);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop_s);
        fifo_cnt_d = fifo_cnt_q + (PTR_W + 1)'(push_s) - (PTR_W + 1)'(pop_s);
        accepted_d = accepted_q + CNT_W'(push_s);
        written_d  = written_q + CNT_W'(pop_s);
        if (accepted_d == LOAD_DEPTH_C) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_DRAIN: begin
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop_s);
        fifo_cnt_d = fifo_cnt_q - (PTR_W + 1)'(pop_s);
        written_d  = written_q + CNT_W'(pop_s);
        if (written_d == LOAD_DEPTH_C) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    host_ready_d = (state_d == S_LOAD) && (fifo_cnt_d != FIFO_FULL_C) &&
                   (accepted_d != LOAD_DEPTH_C);
  end

  // FSM, counters and registered outputs; reset returns everything to IDLE with outputs low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      accepted_q    <= '0;
      written_q     <= '0;
      host_ready_q  <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      busy_q        <= 1'b0;
      load_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      accepted_q   <= accepted_d;
      written_q    <= written_d;
      host_ready_q <= host_ready_d;
      busy_q       <= (state_d == S_LOAD) || (state_d == S_DRAIN);
      load_done_q  <= (state_d == S_DONE);
      mem_wr_en_q  <= pop_s;
      if (pop_s) begin
        // Address wraps naturally at 2^ADDR_WIDTH.
        mem_address_q <= BASE_C + written_q[ADDR_WIDTH-1:0];
        mem_data_q    <= fifo_mem_q[rd_ptr_q];
      end
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_q[wr_ptr_q] <= host_data_in;
    end
  end

  assign host_ready   = host_ready_q;
  assign mem_wr_en    = mem_wr_en_q;
  assign mem_address  = mem_address_q;
  assign mem_data_out = mem_data_q;
  assign busy         = busy_q;
  assign load_done    = load_done_q;
  assign word_count   = written_q;

endmodule

// File: tb/tb_host_input_loader.sv
// Scoreboard bench for host_input_loader: accepted words queue their expected
// memory writes; an independent monitor checks every write strobe in order.
module tb_host_input_loader;

  localparam int DW   = 16;
  localparam int AW   = 11;
  localparam int FD   = 8;
  localparam int LD   = 16;
  localparam int BASE = 32'h7F8;   // 16 words wrap: 0x7F8..0x7FF, 0x000..0x007

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] host_data_in;
  logic          host_valid;
  logic          host_ready;
  logic          mem_grant;
  logic          mem_wr_en;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_out;
  logic          busy;
  logic          load_done;
  logic [AW:0]   word_count;

  host_input_loader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD),
    .LOAD_DEPTH(LD), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .host_data_in(host_data_in), .host_valid(host_valid), .host_ready(host_ready),
    .mem_grant(mem_grant), .mem_wr_en(mem_wr_en), .mem_address(mem_address),
    .mem_data_out(mem_data_out), .busy(busy), .load_done(load_done),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [AW+DW-1:0] exp_q [$];
  logic arm = 1'b0;
  int cyc = 0;
  int n_acc = 0;
  int n_wr = 0;
  int first_acc = -1;
  int first_wr = -1;
  int done_cnt = 0;
  int idx = 0;
  logic [AW-1:0] first_addr = '0;
  logic [AW-1:0] last_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Accept tracker: each handshake queues the write it must produce.
  always @(negedge clk) begin : accept_tracker
    if (arm) begin
      n_acc = 0;
      first_acc = -1;
    end else if (!reset && host_valid && host_ready) begin
      exp_q.push_back({AW'(BASE + n_acc), host_data_in});
      if (n_acc == 0) first_acc = cyc;
      n_acc++;
    end
  end

  // Write monitor: pops and compares on every strobe, checks load_done.
  always @(negedge clk) begin : write_monitor
    logic [AW+DW-1:0] e;
    if (arm) begin
      n_wr = 0;
      first_wr = -1;
    end
    if (mem_wr_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: got strobe at addr 0x%0h, want none", mem_address);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_address), 32'(e[DW+:AW]));
        chk("wr_data", 32'(mem_data_out), 32'(e[DW-1:0]));
      end
      if (n_wr == 0) begin
        first_wr = cyc;
        first_addr = mem_address;
      end
      last_addr = mem_address;
      n_wr++;
    end
    if (load_done) begin
      done_cnt++;
      chk("done_word_count", 32'(word_count), LD);
      chk("done_n_wr", n_wr, LD);
    end
  end

  // One clock: sample handshake at negedge, return #1 after the next posedge.
  task automatic step();
    @(negedge clk);
    if (host_valid && host_ready) idx++;
    @(posedge clk); #1;
  endtask

  task automatic start_load();
    idx = 0;
    arm = 1'b1;
    start = 1'b1;
    step();
    arm = 1'b0;
    start = 1'b0;
  endtask

  task automatic run_until_done(input int vpct, input int gpct,
                                input logic [DW-1:0] dbase, input int budget);
    int d0;
    int c;
    d0 = done_cnt;
    c = 0;
    while (done_cnt == d0 && c < budget) begin
      host_valid   = (int'($urandom_range(99)) < vpct);
      host_data_in = dbase + DW'(idx);
      mem_grant    = (int'($urandom_range(99)) < gpct);
      @(negedge clk);
      if (idx >= LD) chk("ready_low_after_last", 32'(host_ready), 0);
      if (host_valid && host_ready) idx++;
      @(posedge clk); #1;
      c++;
    end
    if (done_cnt == d0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL load_timeout: got no load_done in %0d cycles, want one", budget);
    end
    host_valid = 1'b0;
    mem_grant  = 1'b0;
  endtask

  task automatic end_checks(input string tag);
    chk({tag, "_accepts"}, n_acc, LD);
    chk({tag, "_strobes"}, n_wr, LD);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done_pulse"}, 32'(load_done), 0);
    chk({tag, "_word_count"}, 32'(word_count), LD);
    chk({tag, "_ready"}, 32'(host_ready), 0);
    chk({tag, "_first_addr"}, 32'(first_addr), 32'h7F8);
    chk({tag, "_last_addr"}, 32'(last_addr), 32'h007);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(mem_wr_en), 0);
    chk({tag, "_addr"}, 32'(mem_address), 0);
    chk({tag, "_data"}, 32'(mem_data_out), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(load_done), 0);
    chk({tag, "_count"}, 32'(word_count), 0);
    chk({tag, "_ready"}, 32'(host_ready), 0);
  endtask

  initial begin
    int guard;
    reset = 1'b1; start = 1'b0; host_valid = 1'b0; host_data_in = '0; mem_grant = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Start from IDLE with host_valid already high: nothing accepted before start.
    host_valid = 1'b1; host_data_in = 16'hA000; mem_grant = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("ready_idle", 32'(host_ready), 0);
      @(posedge clk); #1;
    end
    chk("no_accept_idle", exp_q.size(), 0);
    start_load();
    chk("ready_after_start", 32'(host_ready), 1);

    // Basic back-to-back load with grant held high.
    run_until_done(100, 100, 16'hA001, 200);
    chk("first_strobe_latency", first_wr - first_acc, 2);
    end_checks("basic");

    // Backpressure: no grant, the FIFO fills and host_ready drops.
    start_load();
    host_valid = 1'b1; mem_grant = 1'b0;
    repeat (20) begin
      host_data_in = 16'hB000 + DW'(idx);
      step();
    end
    chk("bp_accepts", n_acc, FD);
    chk("bp_strobes", n_wr, 0);
    chk("bp_ready", 32'(host_ready), 0);
    chk("bp_busy", 32'(busy), 1);
    run_until_done(100, 100, 16'hB000, 200);
    end_checks("bp");

    // Random valid/grant stalls over 16 loads (256 words).
    for (int l = 0; l < 16; l++) begin
      start_load();
      run_until_done(60, 50, DW'($urandom), 2000);
      end_checks("rand");
    end

    // start pulsed mid-load must not restart.
    start_load();
    host_valid = 1'b1; mem_grant = 1'b1;
    repeat (5) begin
      host_data_in = 16'hC000 + DW'(idx);
      step();
    end
    host_data_in = 16'hC000 + DW'(idx);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_busy", 32'(busy), 1);
    chk("restart_count_kept", 32'(word_count), 5);
    run_until_done(100, 100, 16'hC000, 200);
    end_checks("restart");

    // Reset after three writes, then a fresh full load.
    start_load();
    host_valid = 1'b1; mem_grant = 1'b1;
    guard = 0;
    while (n_wr < 3 && guard < 50) begin
      host_data_in = 16'hD000 + DW'(idx);
      step();
      guard++;
    end
    chk("mid_reset_writes_seen", 32'(n_wr >= 3), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("mid_reset");
    reset = 1'b0;
    exp_q.delete();
    step();
    chk("post_reset_idle_ready", 32'(host_ready), 0);
    chk("post_reset_idle_busy", 32'(busy), 0);
    start_load();
    run_until_done(100, 100, 16'hE000, 200);
    end_checks("after_reset");

    chk("total_done_pulses", done_cnt, 20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
